// File: rtl/iter_div_unit_if.sv
// rtl/iter_div_unit_if.sv - request/response bundle for the iterative RV32M divider
interface iter_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - iterative restoring divider for DIV/DIVU/REM/REMU (32 CALC + FIXUP + DONE)
// Optional DIV_EARLY_OUT_EN: b==0 and signed overflow skip CALC and go straight to FIXUP.
module iter_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    iter_div_unit_if.slave bus
);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] a_orig;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    cnt;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;
    logic             b_zero;
    logic             ovf;
    logic             dbz;

    logic busy;
    logic accept;
    logic early;

    assign busy   = (state == CALC) || (state == FIXUP);
    assign accept = bus.start && !busy;

    // Operand conditioning at accept: signed ops take magnitudes, unsigned pass through.
    logic             sign_a_in;
    logic             sign_b_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             b_zero_in;
    logic             ovf_in;

    assign sign_a_in = !bus.op[0] && bus.a[WIDTH-1];
    assign sign_b_in = !bus.op[0] && bus.b[WIDTH-1];
    assign abs_a     = sign_a_in ? (~bus.a + 1'b1) : bus.a;
    assign abs_b     = sign_b_in ? (~bus.b + 1'b1) : bus.b;
    assign b_zero_in = (bus.b == '0);
    assign ovf_in    = !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = b_zero_in || ovf_in;
`else
    assign early = 1'b0;
`endif

    // One restoring step: subtract-mode add (S + ~D + 1), Cout set means S >= D.
    logic             msb;
    logic [WIDTH-1:0] s;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             take;

    assign msb      = r[WIDTH-1];
    assign s        = {r[WIDTH-2:0], q[WIDTH-1]};
    assign sub_full = {1'b0, s} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};
    assign diff     = sub_full[WIDTH-1:0];
    assign cout     = sub_full[WIDTH];
    assign take     = msb || cout;

    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] res_fin;

    always_comb begin
        q_fin = neg_q ? (~q + 1'b1) : q;
        r_fin = neg_r ? (~r + 1'b1) : r;
        if (b_zero) begin
            q_fin = '1;
            r_fin = a_orig;
        end else if (ovf) begin
            q_fin = MIN_NEG;
            r_fin = '0;
        end
        res_fin = op_rem ? r_fin : q_fin;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = early ? FIXUP : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= '0;
            r      <= '0;
            d      <= '0;
            a_orig <= '0;
            cnt    <= '0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            ovf    <= 1'b0;
            result <= '0;
            dbz    <= 1'b0;
        end else if (accept) begin
            q      <= abs_a;
            d      <= abs_b;
            r      <= '0;
            cnt    <= '0;
            a_orig <= bus.a;
            op_rem <= bus.op[1];
            neg_q  <= sign_a_in ^ sign_b_in;
            neg_r  <= sign_a_in;
            b_zero <= b_zero_in;
            ovf    <= ovf_in;
        end else if (state == CALC) begin
            r   <= take ? diff : s;
            q   <= {q[WIDTH-2:0], take};
            cnt <= cnt + 1'b1;
        end else if (state == FIXUP) begin
            result <= res_fin;
            dbz    <= b_zero;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = (state == DONE);
    assign bus.result      = result;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_iter_div_unit.sv
// tb/tb_iter_div_unit.sv - vector table plus scoreboard bench for iter_div_unit
module tb_iter_div_unit;
    logic clk = 1'b0;
    logic reset;

    iter_div_unit_if #(.WIDTH(32)) bus ();

    iter_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (is_special(op, a, b)) return 2;
`endif
        return 34;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        if (op[0]) return op[1] ? (a % b) : (a / b);
        return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    endfunction

    task automatic issue(input bit sync, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic dbz);
        exp_t e;
        if (sync) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.res = res;
        e.dbz = dbz;
        e.lat = exp_lat(op, a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(input string name, input int n0);
        exp_t e;
        int   n;
        bit   seen;
        n    = n0;
        seen = 1'b0;
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
        end
        e = sb.pop_front();
        check({name, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " result"}, bus.result, e.res);
            check({name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
            check({name, " latency"}, 32'(n), 32'(e.lat));
        end
    endtask

    initial begin
        int hits;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{2'b01, 32'd100,         32'd7,           32'd14,          1'b0};
        vecs[1]  = '{2'b11, 32'd100,         32'd7,           32'd2,           1'b0};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   1'b0};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   1'b0};
        vecs[4]  = '{2'b00, 32'd5,           32'd0,           32'hFFFF_FFFF,   1'b1};
        vecs[5]  = '{2'b10, 32'd5,           32'd0,           32'd5,           1'b1};
        vecs[6]  = '{2'b00, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1'b0};
        vecs[7]  = '{2'b10, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1'b0};
        vecs[8]  = '{2'b01, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1'b0};
        vecs[9]  = '{2'b11, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1'b0};
        vecs[10] = '{2'b00, 32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'd14,          1'b0};
        vecs[11] = '{2'b10, 32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'hFFFF_FFFE,   1'b0};
        vecs[12] = '{2'b00, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   1'b0};
        vecs[13] = '{2'b10, 32'd7,           32'hFFFF_FFFE,   32'd1,           1'b0};
        vecs[14] = '{2'b01, 32'hFFFF_FFFF,   32'd10,          32'h1999_9999,   1'b0};
        vecs[15] = '{2'b11, 32'hFFFF_FFFF,   32'd10,          32'd5,           1'b0};
        vecs[16] = '{2'b01, 32'd0,           32'd5,           32'd0,           1'b0};
        vecs[17] = '{2'b11, 32'd9,           32'd0,           32'd9,           1'b1};
        vecs[18] = '{2'b01, 32'd9,           32'd0,           32'hFFFF_FFFF,   1'b1};
        vecs[19] = '{2'b01, 32'd1,           32'hFFFF_FFFF,   32'd0,           1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);
            wait_done($sformatf("vec%0d", i), 0);
            @(negedge clk);
            check($sformatf("vec%0d done_pulse", i), 32'(bus.done), 32'd0);
        end

        for (int k = 0; k < 8; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'd0;
            if (k == 5) begin
                rop = 2'b10;
                ra  = 32'h8000_0000;
                rb  = 32'hFFFF_FFFF;
            end
            if (k == 6) rb = 32'($urandom_range(1, 9));
            issue(1'b1, rop, ra, rb, ref_result(rop, ra, rb), rb == 32'd0);
            wait_done($sformatf("rand%0d", k), 0);
        end

        // Start ignored while busy, then back-to-back accept from DONE.
        issue(1'b1, 2'b01, 32'd100, 32'd7, 32'd14, 1'b0);
        repeat (9) @(negedge clk);
        @(negedge clk);
        check("b2b busy_at_10", 32'(bus.busy), 32'd1);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("b2b first", 10);
        issue(1'b0, 2'b01, 32'd9, 32'd3, 32'd3, 1'b0);
        wait_done("b2b second", 0);

        // Reset in the middle of a DIV aborts without a done pulse.
        issue(1'b1, 2'b00, 32'd1000, 32'd3, 32'd333, 1'b0);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        check("midreset result", bus.result, 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        hits  = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) hits++;
        end
        check("midreset no_done", 32'(hits), 32'd0);
        issue(1'b1, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        wait_done("after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
